// File: rtl/f3_sweep_sequencer.sv
// Self-test sequencer: sweeps {x,y} through 00..11 and compares a NOR-only
// evaluation of x AND NOT y against a behavioural one. Define MISMATCH_LOG_EN for fail_mask.
module f3_sweep_sequencer #(
  parameter int HOLD_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       inj_fault,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic       x_o,
  output logic       y_o,
  output logic       r_gate_o,
  output logic       r_expr_o,
  output logic [2:0] err_cnt
`ifdef MISMATCH_LOG_EN
  ,
  output logic [3:0] fail_mask
`endif
);

  localparam int HOLD_EFF = (HOLD_CYCLES < 1) ? 1 : HOLD_CYCLES;
  localparam int CW       = (HOLD_EFF > 1) ? $clog2(HOLD_EFF) : 1;

  typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;

  state_t        state;
  logic [1:0]    idx;
  logic [CW-1:0] hold_cnt;
  logic          not_x, r_gate, r_expr, mismatch;
  logic [2:0]    err_nxt;

  // Gate path uses two-input NORs only; expression path is the plain form.
  assign not_x    = ~(x_o | x_o);
  assign r_gate   = ~(not_x | y_o);
  assign r_expr   = ~(~x_o | y_o);
  assign r_gate_o = r_gate;
  assign r_expr_o = r_expr;

  assign mismatch = (r_gate ^ inj_fault) != r_expr;
  assign err_nxt  = (mismatch && err_cnt < 3'd4) ? err_cnt + 3'd1 : err_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= 2'd0;
      hold_cnt  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      x_o       <= 1'b0;
      y_o       <= 1'b0;
      err_cnt   <= 3'd0;
`ifdef MISMATCH_LOG_EN
      fail_mask <= 4'd0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            state     <= APPLY;
            busy      <= 1'b1;
            idx       <= 2'd0;
            hold_cnt  <= '0;
            {x_o, y_o} <= 2'b00;
            err_cnt   <= 3'd0;
            pass      <= 1'b0;
`ifdef MISMATCH_LOG_EN
            fail_mask <= 4'd0;
`endif
          end
        end
        APPLY, CHECK: begin
          if (abort) begin
            // Cancelled sweeps leave no stale result behind.
            state     <= IDLE;
            busy      <= 1'b0;
            pass      <= 1'b0;
            {x_o, y_o} <= 2'b00;
            err_cnt   <= 3'd0;
`ifdef MISMATCH_LOG_EN
            fail_mask <= 4'd0;
`endif
          end else if (state == APPLY) begin
            if (hold_cnt == CW'(HOLD_EFF - 1)) state <= CHECK;
            else hold_cnt <= hold_cnt + 1'b1;
          end else begin
            err_cnt <= err_nxt;
`ifdef MISMATCH_LOG_EN
            if (mismatch) fail_mask[idx] <= 1'b1;
`endif
            if (idx == 2'd3) begin
              state      <= DONE;
              done       <= 1'b1;
              pass       <= (err_nxt == 3'd0);
              {x_o, y_o} <= 2'b00;
            end else begin
              state      <= APPLY;
              idx        <= idx + 2'd1;
              hold_cnt   <= '0;
              {x_o, y_o} <= idx + 2'd1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
